if_fetch: RTL and testbench

Instruction-fetch stage of the r200 pipeline. Holds the program counter and drives the instruction-memory request handshake. Captures fetched words into the IF/ID pipeline register. It consumes the PC-control outputs `pcsel`, `pcp4_hold` and the IF/ID retire/flush signal, and returns `pcp4` to PC control. Sustains one instruction per cycle with zero-wait memory, and handles memory wait states, decode stalls and redirects.

---
 rtl/if_fetch.sv | 164 ++++++++++++++++
 tb/tb_if_fetch.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, runs the imem request handshake and
// loads the IF/ID register, with a one-entry skid buffer for decode stalls.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  pcsel,
    input  logic [31:0] br_target,
    input  logic [31:0] jmp_target,
    input  logic [31:0] pcp4_hold,
    input  logic        if_id_flush,
    input  logic        id_stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pcp4,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pcp4,
    output logic        if_id_valid
);

    typedef enum logic {
        FETCH   = 1'b0,
        STALLED = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] if_id_instr_q, if_id_instr_d;
    logic [31:0] if_id_pcp4_q, if_id_pcp4_d;
    logic        if_id_valid_q, if_id_valid_d;
    logic [31:0] sk_instr_q, sk_instr_d;
    logic [31:0] sk_pcp4_q, sk_pcp4_d;
    logic        sk_valid_q, sk_valid_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic        pend_valid_q, pend_valid_d;
    logic        drop_q, drop_d;

    logic [31:0] npc_raw;
    logic [31:0] npc;
    logic [31:0] pc_after_fetch;
    logic        redirect;

    assign pcp4        = pc_q + 32'd4;
    assign imem_addr   = pc_q;
    assign imem_req    = (state_q == FETCH) && !rst;
    assign if_id_instr = if_id_instr_q;
    assign if_id_pcp4  = if_id_pcp4_q;
    assign if_id_valid = if_id_valid_q;

    assign redirect = (pcsel != 2'd0);

    always_comb begin
        npc_raw = pcp4;
        case (pcsel)
            2'd0:    npc_raw = pcp4;
            2'd1:    npc_raw = br_target;
            2'd2:    npc_raw = jmp_target;
            default: npc_raw = pcp4_hold;
        endcase
    end

    assign npc = {npc_raw[31:2], 2'b00};
    // A redirect seen during a wait wins over whatever the ack cycle selects.
    assign pc_after_fetch = pend_valid_q ? pend_pc_q : npc;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_pcp4_d  = if_id_pcp4_q;
        if_id_valid_d = if_id_valid_q;
        sk_instr_d    = sk_instr_q;
        sk_pcp4_d     = sk_pcp4_q;
        sk_valid_d    = sk_valid_q;
        pend_pc_d     = pend_pc_q;
        pend_valid_d  = pend_valid_q;
        drop_d        = drop_q;

        case (state_q)
            FETCH: begin
                if (imem_ack) begin
                    pc_d         = pc_after_fetch;
                    pend_valid_d = 1'b0;
                    drop_d       = 1'b0;
                    if (!id_stall) begin
                        if_id_instr_d = imem_rdata;
                        if_id_pcp4_d  = pcp4;
                        if_id_valid_d = !if_id_flush && !drop_q;
                    end else begin
                        sk_instr_d = imem_rdata;
                        sk_pcp4_d  = pcp4;
                        sk_valid_d = !drop_q;
                        state_d    = STALLED;
                        if (if_id_flush) begin
                            if_id_valid_d = 1'b0;
                        end
                    end
                end else begin
                    if (!id_stall || if_id_flush) begin
                        if_id_valid_d = 1'b0;
                    end
                    // Address stays put; remember where to go once the word lands.
                    if (redirect) begin
                        pend_pc_d    = npc;
                        pend_valid_d = 1'b1;
                        drop_d       = 1'b1;
                    end
                end
            end
            STALLED: begin
                if (!id_stall) begin
                    if_id_instr_d = sk_instr_q;
                    if_id_pcp4_d  = sk_pcp4_q;
                    if_id_valid_d = sk_valid_q && !if_id_flush;
                    sk_valid_d    = 1'b0;
                    state_d       = FETCH;
                end else begin
                    if (if_id_flush) begin
                        if_id_valid_d = 1'b0;
                    end
                    if (if_id_flush || redirect) begin
                        sk_valid_d = 1'b0;
                    end
                end
                if (redirect) begin
                    pc_d = npc;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC;
            if_id_instr_q <= 32'd0;
            if_id_pcp4_q  <= 32'd0;
            if_id_valid_q <= 1'b0;
            sk_instr_q    <= 32'd0;
            sk_pcp4_q     <= 32'd0;
            sk_valid_q    <= 1'b0;
            pend_pc_q     <= 32'd0;
            pend_valid_q  <= 1'b0;
            drop_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_pcp4_q  <= if_id_pcp4_d;
            if_id_valid_q <= if_id_valid_d;
            sk_instr_q    <= sk_instr_d;
            sk_pcp4_q     <= sk_pcp4_d;
            sk_valid_q    <= sk_valid_d;
            pend_pc_q     <= pend_pc_d;
            pend_valid_q  <= pend_valid_d;
            drop_q        <= drop_d;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: memory echoes addr|A000_0000, expectations hand-computed.
module tb_if_fetch;

    logic        clk;
    logic        rst;
    logic [1:0]  pcsel;
    logic [31:0] br_target;
    logic [31:0] jmp_target;
    logic [31:0] pcp4_hold;
    logic        if_id_flush;
    logic        id_stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pcp4;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pcp4;
    logic        if_id_valid;

    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_pcp4;
    logic [31:0] w_instr;
    logic [31:0] w_ipcp4;
    logic        w_valid;

    int tests_run;
    int tests_failed;

    if_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .pcsel(pcsel), .br_target(br_target),
        .jmp_target(jmp_target), .pcp4_hold(pcp4_hold), .if_id_flush(if_id_flush),
        .id_stall(id_stall), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pcp4(pcp4),
        .if_id_instr(if_id_instr), .if_id_pcp4(if_id_pcp4), .if_id_valid(if_id_valid)
    );

    if_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst), .pcsel(pcsel), .br_target(br_target),
        .jmp_target(jmp_target), .pcp4_hold(pcp4_hold), .if_id_flush(if_id_flush),
        .id_stall(id_stall), .imem_req(w_req), .imem_addr(w_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pcp4(w_pcp4),
        .if_id_instr(w_instr), .if_id_pcp4(w_ipcp4), .if_id_valid(w_valid)
    );

    assign imem_rdata = imem_addr | 32'hA000_0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: %h", tag, got);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic chk_if(input string tag, input logic [31:0] addr, input logic [31:0] instr,
                          input logic [31:0] ipc4, input logic vld);
        chk({tag, ".addr"}, imem_addr, addr);
        chk({tag, ".instr"}, if_id_instr, instr);
        chk({tag, ".pcp4"}, if_id_pcp4, ipc4);
        chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, vld});
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst = 1'b1; pcsel = 2'd0; br_target = 32'd0; jmp_target = 32'd0;
        pcp4_hold = 32'd0; if_id_flush = 1'b0; id_stall = 1'b0; imem_ack = 1'b0;

        // Reset values
        next_cycle(); mid();
        chk("rst.req", {31'd0, imem_req}, 32'd0);
        chk_if("rst", 32'h0, 32'h0, 32'h0, 1'b0);
        chk("rst.wrap_addr", w_addr, 32'hFFFF_FFFC);

        // Zero-wait streaming
        next_cycle(); rst = 1'b0; imem_ack = 1'b1; mid();
        chk("c0.req", {31'd0, imem_req}, 32'd1);
        chk_if("c0", 32'h0, 32'h0, 32'h0, 1'b0);
        chk("c0.wrap_pcp4", w_pcp4, 32'h0);
        next_cycle(); mid();
        chk_if("c1", 32'h4, 32'hA000_0000, 32'h4, 1'b1);
        chk("c1.wrap_addr", w_addr, 32'h0);
        next_cycle(); imem_ack = 1'b0; mid();
        chk_if("c2", 32'h8, 32'hA000_0004, 32'h8, 1'b1);

        // Ack every third cycle: two bubbles, address held
        next_cycle(); mid();
        chk_if("c3", 32'h8, 32'hA000_0004, 32'h8, 1'b0);
        next_cycle(); imem_ack = 1'b1; mid();
        chk_if("c4", 32'h8, 32'hA000_0004, 32'h8, 1'b0);
        next_cycle(); imem_ack = 1'b0; mid();
        chk_if("c5", 32'hC, 32'hA000_0008, 32'hC, 1'b1);
        next_cycle(); mid();
        chk_if("c6", 32'hC, 32'hA000_0008, 32'hC, 1'b0);
        next_cycle(); imem_ack = 1'b1; mid();
        chk_if("c7", 32'hC, 32'hA000_0008, 32'hC, 1'b0);

        // Branch with flush, then mispredict recovery via pcp4_hold
        next_cycle(); pcsel = 2'd1; br_target = 32'h100; if_id_flush = 1'b1; mid();
        chk_if("c8", 32'h10, 32'hA000_000C, 32'h10, 1'b1);
        next_cycle(); pcsel = 2'd3; pcp4_hold = 32'hC; if_id_flush = 1'b0; mid();
        chk_if("c9", 32'h100, 32'hA000_0010, 32'h14, 1'b0);
        next_cycle(); pcsel = 2'd0; mid();
        chk_if("c10", 32'hC, 32'hA000_0100, 32'h104, 1'b1);

        // Stall for 4 cycles: one wait cycle on 0x10, then ack into the skid buffer
        next_cycle(); imem_ack = 1'b0; id_stall = 1'b1; mid();
        chk_if("c11", 32'h10, 32'hA000_000C, 32'h10, 1'b1);
        next_cycle(); imem_ack = 1'b1; mid();
        chk("c12.req", {31'd0, imem_req}, 32'd1);
        chk_if("c12", 32'h10, 32'hA000_000C, 32'h10, 1'b1);
        next_cycle(); mid();
        chk("c13.req", {31'd0, imem_req}, 32'd0);
        chk("c13.instr", if_id_instr, 32'hA000_000C);
        next_cycle(); mid();
        chk("c14.req", {31'd0, imem_req}, 32'd0);
        next_cycle(); id_stall = 1'b0; mid();
        chk("c15.req", {31'd0, imem_req}, 32'd0);
        chk("c15.instr", if_id_instr, 32'hA000_000C);
        next_cycle(); mid();
        chk("c16.req", {31'd0, imem_req}, 32'd1);
        chk_if("c16", 32'h14, 32'hA000_0010, 32'h14, 1'b1);
        next_cycle(); imem_ack = 1'b0; pcsel = 2'd2; jmp_target = 32'h40; mid();
        chk_if("c17", 32'h18, 32'hA000_0014, 32'h18, 1'b1);

        // Redirect during a wait: late word dropped, jump target fetched next
        next_cycle(); pcsel = 2'd0; imem_ack = 1'b1; mid();
        chk_if("c18", 32'h18, 32'hA000_0014, 32'h18, 1'b0);
        next_cycle(); mid();
        chk_if("c19", 32'h40, 32'hA000_0018, 32'h1C, 1'b0);
        next_cycle(); imem_ack = 1'b0; mid();
        chk_if("c20", 32'h44, 32'hA000_0040, 32'h44, 1'b1);

        // Reset pulsed mid-wait, with an ack during reset
        next_cycle(); #2 rst = 1'b1; #1;
        chk("r.req", {31'd0, imem_req}, 32'd0);
        chk_if("r", 32'h0, 32'h0, 32'h0, 1'b0);
        imem_ack = 1'b1;
        next_cycle(); mid();
        chk_if("r2", 32'h0, 32'h0, 32'h0, 1'b0);
        next_cycle(); rst = 1'b0; mid();
        chk("r3.req", {31'd0, imem_req}, 32'd1);
        chk_if("r3", 32'h0, 32'h0, 32'h0, 1'b0);
        next_cycle(); mid();
        chk_if("r4", 32'h4, 32'hA000_0000, 32'h4, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
